// File: rtl/stopwatch_if.sv
// Command/display bundle between a stopwatch controller and its user.
// Commands are one-cycle pulses; display outputs are registered-state driven.
interface stopwatch_if;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [15:0] disp;
    logic        running;
    logic        lap_active;
    logic        ovf;

    modport master (
        output start_stop, lap, clear,
        input  disp, running, lap_active, ovf
    );

    modport slave (
        input  start_stop, lap, clear,
        output disp, running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Millisecond stopwatch: prescaled tick drives a 4-digit BCD chain (s.ms),
// with run/pause/lap/clear control and a sticky wrap flag.
module stopwatch_bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] val,
    output logic       carry
);
    assign carry = inc && (val == 4'd9);

    always_ff @(posedge clk) begin
        if (rst || clr)
            val <= 4'd0;
        else if (inc)
            val <= carry ? 4'd0 : val + 4'd1;
    end
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  sw
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic [3:0][3:0] digits;
    logic [3:0]      inc;
    logic [3:0]      carry;
    logic [15:0]     lap_q;
    logic            ovf_q;
    logic            cmd_ss, cmd_lap, cmd_clr;
    logic            active, tick, capture, zero;

    // Only the highest-priority command survives, even if the state ignores it.
    assign cmd_ss  = sw.start_stop;
    assign cmd_lap = sw.lap & ~sw.start_stop;
    assign cmd_clr = sw.clear & ~sw.lap & ~sw.start_stop;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        zero      = 1'b0;
        case (state)
            IDLE:  if (cmd_ss) state_nxt = RUN;
            RUN: begin
                if (cmd_ss)
                    state_nxt = PAUSE;
                else if (cmd_lap) begin
                    state_nxt = LAP;
                    capture   = 1'b1;
                end
            end
            LAP: begin
                if (cmd_ss)
                    state_nxt = PAUSE;
                else if (cmd_lap)
                    state_nxt = RUN;
            end
            PAUSE: begin
                if (cmd_ss)
                    state_nxt = RUN;
                else if (cmd_clr) begin
                    state_nxt = IDLE;
                    zero      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active = (state == RUN) || (state == LAP);
    assign tick   = active && (presc == PW'(TICK_DIV - 1));

    // Prescaler holds outside RUN/LAP so a resume picks up the partial ms.
    always_ff @(posedge clk) begin
        if (rst || zero)
            presc <= '0;
        else if (active)
            presc <= tick ? '0 : presc + PW'(1);
    end

    assign inc[0] = tick;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        if (g > 0) begin : g_chain
            assign inc[g] = carry[g-1];
        end
        stopwatch_bcd_digit u_dig (
            .clk   (clk),
            .rst   (rst),
            .clr   (zero),
            .inc   (inc[g]),
            .val   (digits[g]),
            .carry (carry[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || zero)
            ovf_q <= 1'b0;
        else if (carry[3])
            ovf_q <= 1'b1;
    end

    // Captures the pre-edge digits, so a coincident tick is not included.
    always_ff @(posedge clk) begin
        if (rst)
            lap_q <= 16'h0000;
        else if (capture)
            lap_q <= digits;
    end

    assign sw.disp       = (state == LAP) ? lap_q : digits;
    assign sw.running    = active;
    assign sw.lap_active = (state == LAP);
    assign sw.ovf        = ovf_q;
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clock cycles per 1 ms tick (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_stop, input, 1 bit: one-cycle command pulse that toggles run/pause.
REQ-005 SHALL have port lap, input, 1 bit: one-cycle command pulse that freezes or releases the display.
REQ-006 SHALL have port clear, input, 1 bit: one-cycle command pulse that zeroes the time when paused.
REQ-007 SHALL have port disp, output, 16 bits: BCD time [15:12]=s, [11:8]=100 ms, [7:4]=10 ms, [3:0]=1 ms.
REQ-008 SHALL have port running, output, 1 bit: high in RUN or LAP.
REQ-009 SHALL have port lap_active, output, 1 bit: high in LAP.
REQ-010 SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-011 SHALL implement a 4-state FSM: IDLE, RUN, PAUSE, LAP; state, prescaler, digits, lap register and ovf all registered.
REQ-012 SHALL evaluate commands with priority start_stop > lap > clear; only the highest-priority asserted command acts in a cycle, and the others are dropped.
REQ-013 SHALL transition IDLE -> RUN on start_stop; lap and clear ignored in IDLE.
REQ-014 SHALL transition RUN -> PAUSE on start_stop, and RUN -> LAP on lap; clear ignored in RUN.
REQ-015 SHALL transition LAP -> PAUSE on start_stop, and LAP -> RUN on lap; clear ignored in LAP.
REQ-016 SHALL transition PAUSE -> RUN on start_stop, and PAUSE -> IDLE on clear; lap ignored in PAUSE.
REQ-017 SHALL, on the PAUSE -> IDLE edge, zero the digits, prescaler and ovf.
REQ-018 SHALL use a prescaler of width clog2(TICK_DIV) that increments only while in RUN or LAP, and holds its value in PAUSE and IDLE.
REQ-019 SHALL generate a tick when the prescaler equals TICK_DIV-1 in RUN or LAP; the prescaler wraps to 0 on that edge and the digits increment on that same edge.
REQ-020 SHALL count the digits as a cascaded BCD chain: each digit 0..9; a digit wraps 9->0 and carries into the next; no digit ever holds a value above 9.
REQ-021 SHALL, on a tick at 9999, wrap the digits to 0000 and set ovf; ovf stays high until PAUSE -> IDLE or rst.
REQ-022 SHALL make the first tick after a start_stop pulse in cycle k (from IDLE) increment the digits at edge k+TICK_DIV.
REQ-023 SHALL make resume from PAUSE continue from the held prescaler value, so no partial millisecond is lost or restarted.
REQ-024 SHALL, on entry to LAP, capture into the lap register the digit value held before that edge, even if a tick occurs on the same edge.
REQ-025 SHALL drive disp = lap register in LAP and disp = live digits in all other states; the live digits keep counting during LAP.
REQ-026 SHALL, when leaving LAP by start_stop, show live (now paused) digits in PAUSE.

Reset
REQ-027 SHALL, when rst is high at a clock edge, force state=IDLE, prescaler=0, digits=0000, lap register=0000 and ovf=0, regardless of state or any command input.
REQ-028 SHALL, one cycle after a reset edge, hold disp=16'h0000, running=0, lap_active=0 and ovf=0.
REQ-029 SHALL, when reset is applied mid-run, discard any partial prescaler count; the next start_stop behaves as in REQ-022.

Verification (TICK_DIV=4)
REQ-030 SHALL test basic count: start_stop pulse at cycle 0 -> disp=0x0001 after edge 4, 0x0010 after edge 40, running=1 throughout.
REQ-031 SHALL test pause/resume: pause at prescaler=2, hold 50 cycles, resume -> disp frozen during pause; next increment occurs 2 cycles after the resume edge (REQ-023).
REQ-032 SHALL test lap: lap at disp=0x0012 -> disp holds 0x0012 and lap_active=1 for 20 cycles; second lap -> disp=0x0017.
REQ-033 SHALL test wrap and clear: run to 9999, one more tick -> disp=0x0000, ovf=1; pause then clear -> IDLE, ovf=0, disp=0x0000.
REQ-034 SHALL test priority and ignored commands: start_stop+lap+clear together in RUN -> PAUSE only, no capture; clear in RUN -> no effect; lap in PAUSE -> no effect.
REQ-035 SHALL test reset mid-LAP: rst high for 1 cycle -> all outputs zero next cycle; start_stop -> first tick 4 cycles later.
